// File: rtl/rename_issue_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// rename_issue_ctrl_pkg
//
// Shared definitions for the rename/issue sequencing slice: the default
// processor-wide sizes (tag width, result width, tag pool depth, number of
// functional units, architectural register count used by the rename table),
// the free-list operation encoding and a small modular-add helper used by the
// round-robin arbiter.
//
// No ports (package).
// -----------------------------------------------------------------------------
package rename_issue_ctrl_pkg;

    // Default machine sizes shared by the rename table and its controller.
    localparam int TAG_WIDTH_DEF  = 8;
    localparam int DATA_WIDTH_DEF = 128;
    localparam int NUM_TAGS_DEF   = 16;
    localparam int NUM_FU_DEF     = 4;
    localparam int NUM_ARCH_REGS  = 16;

    // What the free list does on a given edge once push/pop have been
    // qualified against the current occupancy.
    typedef enum logic [1:0] {
        FL_IDLE = 2'b00,
        FL_POP  = 2'b01,
        FL_PUSH = 2'b10,
        FL_BOTH = 2'b11
    } flOp_e;

    // (a + b) mod n for small non-negative operands with a, b < n.
    function automatic int wrapAdd(input int a, input int b, input int n);
        int s;
        s = a + b;
        if (s >= n) begin
            s = s - n;
        end
        return s;
    endfunction

endpackage

// File: rtl/rename_issue_ctrl_tag_free_list.sv
// -----------------------------------------------------------------------------
// tag_free_list
//
// Circular FIFO holding the instruction tags that are currently free. The
// head entry is offered to dispatch; tags coming back from the broadcast bus
// are appended at the tail. A push into a full pool is dropped and latches a
// sticky overflow flag that only reset clears. Reset refills the pool with
// tags 0..NUM_TAGS-1 in order.
//
// Ports
//   clk          in   clock, all state on rising edge
//   rst          in   synchronous active-high reset
//   pop_i        in   consume the head tag (ignored when empty)
//   push_i       in   return push_tag_i to the pool
//   push_tag_i   in   tag being returned
//   head_tag_o   out  tag at the head of the pool
//   count_o      out  number of free tags
//   overflow_o   out  sticky: a push arrived while the pool was full
// -----------------------------------------------------------------------------
module tag_free_list
    import rename_issue_ctrl_pkg::*;
#(
    parameter int TAG_WIDTH = TAG_WIDTH_DEF,
    parameter int NUM_TAGS  = NUM_TAGS_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         pop_i,
    input  logic                         push_i,
    input  logic [TAG_WIDTH-1:0]         push_tag_i,
    output logic [TAG_WIDTH-1:0]         head_tag_o,
    output logic [$clog2(NUM_TAGS):0]    count_o,
    output logic                         overflow_o
);

    localparam int PTR_W = $clog2(NUM_TAGS);
    localparam int CNT_W = PTR_W + 1;

    logic [TAG_WIDTH-1:0] tagMem_q [NUM_TAGS];
    logic [PTR_W-1:0]     headPtr_q, headPtr_d;
    logic [PTR_W-1:0]     tailPtr_q, tailPtr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 overflow_q, overflow_d;

    logic  poolFull;
    logic  poolEmpty;
    logic  pushOk;
    logic  popOk;
    flOp_e op;

    assign poolFull  = (count_q == CNT_W'(NUM_TAGS));
    assign poolEmpty = (count_q == '0);
    assign pushOk    = push_i && !poolFull;
    assign popOk     = pop_i && !poolEmpty;

    // Classify the edge so the pointer/count update below reads as a plain
    // four-way decision. A push that would overflow has already been
    // filtered out, so FL_BOTH never needs to worry about capacity.
    always_comb begin
        op = FL_IDLE;
        if (pushOk && popOk) begin
            op = FL_BOTH;
        end else if (pushOk) begin
            op = FL_PUSH;
        end else if (popOk) begin
            op = FL_POP;
        end
    end

    // Next-state for pointers, count and the sticky overflow flag. Pointers
    // wrap naturally because the pool depth is a power of two. With a
    // simultaneous push and pop both pointers move and the count stays put.
    always_comb begin
        headPtr_d  = headPtr_q;
        tailPtr_d  = tailPtr_q;
        count_d    = count_q;
        overflow_d = overflow_q | (push_i & poolFull);
        case (op)
            FL_POP: begin
                headPtr_d = headPtr_q + PTR_W'(1);
                count_d   = count_q - CNT_W'(1);
            end
            FL_PUSH: begin
                tailPtr_d = tailPtr_q + PTR_W'(1);
                count_d   = count_q + CNT_W'(1);
            end
            FL_BOTH: begin
                headPtr_d = headPtr_q + PTR_W'(1);
                tailPtr_d = tailPtr_q + PTR_W'(1);
            end
            default: begin
            end
        endcase
    end

    // State registers. Reset reloads every slot with its own index so the
    // first NUM_TAGS dispatches after reset receive tags 0,1,2,... in order;
    // afterwards a slot is only rewritten when an accepted push lands on it.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_TAGS; i++) begin
                tagMem_q[i] <= TAG_WIDTH'(i);
            end
            headPtr_q  <= '0;
            tailPtr_q  <= '0;
            count_q    <= CNT_W'(NUM_TAGS);
            overflow_q <= 1'b0;
        end else begin
            if (pushOk) begin
                tagMem_q[tailPtr_q] <= push_tag_i;
            end
            headPtr_q  <= headPtr_d;
            tailPtr_q  <= tailPtr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    assign head_tag_o = tagMem_q[headPtr_q];
    assign count_o    = count_q;
    assign overflow_o = overflow_q;

endmodule

// File: rtl/rename_issue_ctrl.sv
// -----------------------------------------------------------------------------
// rename_issue_ctrl
//
// Sequencing controller for the register rename table. It hands one tag from
// the free pool to each dispatched instruction (zero-latency allocation) and
// drives the table's write port. It also arbitrates the single result
// broadcast bus among the functional units with a round-robin pointer and
// drives a registered broadcast to the table. Every broadcast tag is returned
// to the pool at the end of the cycle in which it is broadcast.
//
// Ports
//   clk                in   clock, all state on rising edge
//   rst                in   synchronous active-high reset
//   disp_valid_i       in   decode presents an instruction for renaming
//   disp_ready_o       out  a free tag is available
//   disp_tag_o         out  tag at the free-list head
//   rt_input_enable_o  out  rename-table write enable
//   rt_instr_tag_o     out  tag written into the rename table
//   fu_req_i           in   per-FU broadcast request
//   fu_tag_i           in   per-FU result tag, FU i at [i*TAG_WIDTH +: TAG_WIDTH]
//   fu_data_i          in   per-FU result data, same packing
//   fu_grant_o         out  one-hot grant (combinational)
//   bcast_o            out  registered broadcast strobe
//   bcast_tag_o        out  registered broadcast tag
//   bcast_data_o       out  registered broadcast data
//   free_count_o       out  tags currently free
//   err_overflow_o     out  sticky: a tag was returned into a full pool
// -----------------------------------------------------------------------------
module rename_issue_ctrl
    import rename_issue_ctrl_pkg::*;
#(
    parameter int TAG_WIDTH  = TAG_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int NUM_TAGS   = NUM_TAGS_DEF,
    parameter int NUM_FU     = NUM_FU_DEF
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           disp_valid_i,
    output logic                           disp_ready_o,
    output logic [TAG_WIDTH-1:0]           disp_tag_o,
    output logic                           rt_input_enable_o,
    output logic [TAG_WIDTH-1:0]           rt_instr_tag_o,
    input  logic [NUM_FU-1:0]              fu_req_i,
    input  logic [NUM_FU*TAG_WIDTH-1:0]    fu_tag_i,
    input  logic [NUM_FU*DATA_WIDTH-1:0]   fu_data_i,
    output logic [NUM_FU-1:0]              fu_grant_o,
    output logic                           bcast_o,
    output logic [TAG_WIDTH-1:0]           bcast_tag_o,
    output logic [DATA_WIDTH-1:0]          bcast_data_o,
    output logic [$clog2(NUM_TAGS):0]      free_count_o,
    output logic                           err_overflow_o
);

    localparam int FU_IDX_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
    localparam int CNT_W    = $clog2(NUM_TAGS) + 1;

    logic [TAG_WIDTH-1:0]  headTag;
    logic [CNT_W-1:0]      freeCount;
    logic                  overflow;
    logic                  popTag;

    logic [2*NUM_FU-1:0]   reqDouble;
    logic [NUM_FU-1:0]     reqRot;
    logic                  grantValid;
    int                    grantInt;
    logic [FU_IDX_W-1:0]   grantIdx;

    logic [FU_IDX_W-1:0]   rrPtr_q, rrPtr_d;
    logic                  bcast_q, bcast_d;
    logic [TAG_WIDTH-1:0]  bcastTag_q, bcastTag_d;
    logic [DATA_WIDTH-1:0] bcastData_q, bcastData_d;

    // ------------------------------------------------------------------
    // Dispatch side. Readiness comes from the registered count only, so a
    // tag returning this very cycle cannot be handed out until next cycle.
    // While reset is held the outputs show their reset values and the table
    // write is suppressed, since any allocation in that cycle is discarded.
    // ------------------------------------------------------------------
    assign disp_ready_o      = rst ? 1'b1 : (freeCount != '0);
    assign disp_tag_o        = rst ? '0 : headTag;
    assign rt_instr_tag_o    = disp_tag_o;
    assign rt_input_enable_o = disp_valid_i & disp_ready_o & ~rst;
    assign popTag            = disp_valid_i & disp_ready_o;

    tag_free_list #(
        .TAG_WIDTH (TAG_WIDTH),
        .NUM_TAGS  (NUM_TAGS)
    ) u_free_list (
        .clk        (clk),
        .rst        (rst),
        .pop_i      (popTag),
        .push_i     (bcast_q),
        .push_tag_i (bcastTag_q),
        .head_tag_o (headTag),
        .count_o    (freeCount),
        .overflow_o (overflow)
    );

    assign free_count_o   = freeCount;
    assign err_overflow_o = overflow;

    // ------------------------------------------------------------------
    // Round-robin arbiter: rotate the request vector so the FU at the
    // round-robin pointer sits at bit 0, pick the lowest set bit, then
    // rotate the winner's index back into FU numbering. The loop runs from
    // the top down so the lowest requesting position is the last to write.
    // ------------------------------------------------------------------
    assign reqDouble = {fu_req_i, fu_req_i};
    assign reqRot    = NUM_FU'(reqDouble >> rrPtr_q);

    always_comb begin
        grantValid = 1'b0;
        grantInt   = 0;
        for (int j = NUM_FU - 1; j >= 0; j--) begin
            if (reqRot[j]) begin
                grantValid = 1'b1;
                grantInt   = wrapAdd(j, int'(rrPtr_q), NUM_FU);
            end
        end
    end

    assign grantIdx   = FU_IDX_W'(grantInt);
    assign fu_grant_o = (grantValid && !rst) ? (NUM_FU'(1) << grantIdx) : '0;

    // ------------------------------------------------------------------
    // Broadcast register next-state. A granted FU's tag and data are
    // captured for one cycle of broadcast and the pointer moves just past
    // the winner, which bounds any continuously requesting FU's wait to
    // NUM_FU-1 cycles. Without a grant the strobe drops but tag/data hold.
    // ------------------------------------------------------------------
    always_comb begin
        bcast_d     = 1'b0;
        bcastTag_d  = bcastTag_q;
        bcastData_d = bcastData_q;
        rrPtr_d     = rrPtr_q;
        if (grantValid) begin
            bcast_d     = 1'b1;
            bcastTag_d  = fu_tag_i[grantInt*TAG_WIDTH +: TAG_WIDTH];
            bcastData_d = fu_data_i[grantInt*DATA_WIDTH +: DATA_WIDTH];
            rrPtr_d     = FU_IDX_W'(wrapAdd(grantInt, 1, NUM_FU));
        end
    end

    // Broadcast and arbiter state. Reset drops any broadcast in flight, so
    // the tag it carried is never returned to the (refilled) pool.
    always_ff @(posedge clk) begin
        if (rst) begin
            bcast_q     <= 1'b0;
            bcastTag_q  <= '0;
            bcastData_q <= '0;
            rrPtr_q     <= '0;
        end else begin
            bcast_q     <= bcast_d;
            bcastTag_q  <= bcastTag_d;
            bcastData_q <= bcastData_d;
            rrPtr_q     <= rrPtr_d;
        end
    end

    assign bcast_o      = bcast_q;
    assign bcast_tag_o  = bcastTag_q;
    assign bcast_data_o = bcastData_q;

endmodule

// File: tb/tb_rename_issue_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rename_issue_ctrl
//
// Directed bench for rename_issue_ctrl. A queue-based model of the tag pool
// and a loop-based round-robin arbiter predict every output on every cycle;
// directed scenarios additionally pin key values with literal expectations.
// -----------------------------------------------------------------------------
module tb_rename_issue_ctrl;

    localparam int TW  = 8;
    localparam int DW  = 128;
    localparam int NT  = 16;
    localparam int NF  = 4;
    localparam int CW  = $clog2(NT) + 1;

    logic               clk;
    logic               rst;
    logic               dispValid;
    logic               dispReady;
    logic [TW-1:0]      dispTag;
    logic               rtInputEnable;
    logic [TW-1:0]      rtInstrTag;
    logic [NF-1:0]      fuReq;
    logic [NF*TW-1:0]   fuTag;
    logic [NF*DW-1:0]   fuData;
    logic [NF-1:0]      fuGrant;
    logic               bcast;
    logic [TW-1:0]      bcastTag;
    logic [DW-1:0]      bcastData;
    logic [CW-1:0]      freeCount;
    logic               errOverflow;

    int nChecks = 0;
    int nFail   = 0;
    logic checkEn = 1'b0;

    rename_issue_ctrl #(
        .TAG_WIDTH  (TW),
        .DATA_WIDTH (DW),
        .NUM_TAGS   (NT),
        .NUM_FU     (NF)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .disp_valid_i      (dispValid),
        .disp_ready_o      (dispReady),
        .disp_tag_o        (dispTag),
        .rt_input_enable_o (rtInputEnable),
        .rt_instr_tag_o    (rtInstrTag),
        .fu_req_i          (fuReq),
        .fu_tag_i          (fuTag),
        .fu_data_i         (fuData),
        .fu_grant_o        (fuGrant),
        .bcast_o           (bcast),
        .bcast_tag_o       (bcastTag),
        .bcast_data_o      (bcastData),
        .free_count_o      (freeCount),
        .err_overflow_o    (errOverflow)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Common comparison: counts every check and reports any difference.
    task automatic checkOutput(input string name, input logic [DW-1:0] act,
                               input logic [DW-1:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: the free pool is a plain queue, the arbiter a
    // search starting at the round-robin index, the broadcast a one-cycle
    // delayed copy of the winner's tag and data.
    // ------------------------------------------------------------------
    logic [TW-1:0] freeQ[$];
    logic          mBcast;
    logic [TW-1:0] mTag;
    logic [DW-1:0] mData;
    int            mRr;
    logic          mErr;
    int            mGrant;
    logic          mPop;
    logic          mFull;

    function automatic int modelGrant();
        int idx;
        for (int k = 0; k < NF; k++) begin
            idx = (mRr + k) % NF;
            if (fuReq[idx]) return idx;
        end
        return -1;
    endfunction

    // Model state advances on each rising edge from the inputs of the
    // cycle just ending.
    always @(posedge clk) begin
        if (rst) begin
            freeQ.delete();
            for (int i = 0; i < NT; i++) freeQ.push_back(TW'(i));
            mBcast = 1'b0;
            mTag   = '0;
            mData  = '0;
            mRr    = 0;
            mErr   = 1'b0;
        end else begin
            mGrant = modelGrant();
            mPop   = dispValid && (freeQ.size() != 0);
            mFull  = (freeQ.size() == NT);
            if (mPop) void'(freeQ.pop_front());
            if (mBcast) begin
                if (mFull) mErr = 1'b1;
                else freeQ.push_back(mTag);
            end
            if (mGrant >= 0) begin
                mBcast = 1'b1;
                mTag   = fuTag[mGrant*TW +: TW];
                mData  = fuData[mGrant*DW +: DW];
                mRr    = (mGrant + 1) % NF;
            end else begin
                mBcast = 1'b0;
            end
        end
    end

    // Per-cycle comparison against the model, sampled mid-cycle.
    int            eGrantIdx;
    logic [NF-1:0] eGrant;
    logic          eReady;
    logic [TW-1:0] eTag;
    always @(negedge clk) begin
        if (checkEn) begin
            eGrantIdx = rst ? -1 : modelGrant();
            eGrant    = (eGrantIdx >= 0) ? NF'(1) << eGrantIdx : '0;
            eReady    = rst ? 1'b1 : (freeQ.size() != 0);
            eTag      = rst ? '0 : ((freeQ.size() != 0) ? freeQ[0] : '0);
            checkOutput("model fu_grant", DW'(fuGrant), DW'(eGrant));
            checkOutput("model disp_ready", DW'(dispReady), DW'(eReady));
            checkOutput("model rt_input_enable", DW'(rtInputEnable),
                        DW'(dispValid & eReady & ~rst));
            if (eReady) begin
                checkOutput("model disp_tag", DW'(dispTag), DW'(eTag));
                checkOutput("model rt_instr_tag", DW'(rtInstrTag), DW'(eTag));
            end
            checkOutput("model bcast", DW'(bcast), DW'(mBcast));
            checkOutput("model bcast_tag", DW'(bcastTag), DW'(mTag));
            checkOutput("model bcast_data", bcastData, mData);
            checkOutput("model free_count", DW'(freeCount), DW'(freeQ.size()));
            checkOutput("model err_overflow", DW'(errOverflow), DW'(mErr));
        end
    end

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive dispatch valid and the FU request vector for the coming cycle.
    task automatic applyStimulus(input logic dv, input logic [NF-1:0] req);
        dispValid = dv;
        fuReq     = req;
    endtask

    task automatic setFu(input int i, input logic [TW-1:0] t, input logic [DW-1:0] d);
        fuTag[i*TW +: TW]  = t;
        fuData[i*DW +: DW] = d;
    endtask

    logic [NF-1:0] grantSeq [5];

    initial begin
        grantSeq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        rst = 1'b1;
        dispValid = 1'b0;
        fuReq = '1;
        fuTag = '0;
        fuData = '0;

        // Reset values, with requests present to show grants are held off.
        tick();
        checkEn = 1'b1;
        @(negedge clk);
        checkOutput("reset bcast", DW'(bcast), 0);
        checkOutput("reset bcast_tag", DW'(bcastTag), 0);
        checkOutput("reset bcast_data", bcastData, 0);
        checkOutput("reset err_overflow", DW'(errOverflow), 0);
        checkOutput("reset free_count", DW'(freeCount), 16);
        checkOutput("reset disp_ready", DW'(dispReady), 1);
        checkOutput("reset disp_tag", DW'(dispTag), 0);
        checkOutput("reset fu_grant", DW'(fuGrant), 0);
        tick();
        rst = 1'b0;

        // Drain the pool: tags come out 0..15 in order, then ready drops.
        applyStimulus(1'b1, 4'b0000);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            checkOutput("drain disp_tag", DW'(dispTag), DW'(k));
            checkOutput("drain disp_ready", DW'(dispReady), 1);
            tick();
        end
        @(negedge clk);
        checkOutput("empty disp_ready", DW'(dispReady), 0);
        checkOutput("empty free_count", DW'(freeCount), 0);
        checkOutput("empty rt_input_enable", DW'(rtInputEnable), 0);
        tick();

        // Empty pool, FU1 returns tag 5.
        applyStimulus(1'b0, 4'b0010);
        setFu(1, 8'd5, 128'hAB);
        @(negedge clk);
        checkOutput("fu1 grant", DW'(fuGrant), 4'b0010);
        tick();
        applyStimulus(1'b0, 4'b0000);
        @(negedge clk);
        checkOutput("fu1 bcast", DW'(bcast), 1);
        checkOutput("fu1 bcast_tag", DW'(bcastTag), 5);
        checkOutput("fu1 bcast_data", bcastData, 128'hAB);
        checkOutput("fu1 ready same cycle", DW'(dispReady), 0);
        tick();
        @(negedge clk);
        checkOutput("fu1 ready after push", DW'(dispReady), 1);
        checkOutput("fu1 disp_tag", DW'(dispTag), 5);
        checkOutput("fu1 free_count", DW'(freeCount), 1);
        tick();

        // Build count=3 (5,7,8), then pop and push tag 9 together.
        applyStimulus(1'b0, 4'b1100);
        setFu(2, 8'd7, 128'h77);
        setFu(3, 8'd8, 128'h88);
        @(negedge clk);
        checkOutput("rr fu2 grant", DW'(fuGrant), 4'b0100);
        tick();
        applyStimulus(1'b0, 4'b1000);
        @(negedge clk);
        checkOutput("rr fu3 grant", DW'(fuGrant), 4'b1000);
        tick();
        applyStimulus(1'b0, 4'b0001);
        setFu(0, 8'd9, 128'h99);
        @(negedge clk);
        checkOutput("rr fu0 grant", DW'(fuGrant), 4'b0001);
        checkOutput("pre count", DW'(freeCount), 2);
        tick();
        applyStimulus(1'b1, 4'b0000);
        @(negedge clk);
        checkOutput("both count", DW'(freeCount), 3);
        checkOutput("both bcast_tag", DW'(bcastTag), 9);
        checkOutput("both disp_tag", DW'(dispTag), 5);
        tick();
        @(negedge clk);
        checkOutput("after both count", DW'(freeCount), 3);
        checkOutput("after both disp_tag", DW'(dispTag), 7);
        tick();
        @(negedge clk);
        checkOutput("seq disp_tag 8", DW'(dispTag), 8);
        tick();
        @(negedge clk);
        checkOutput("seq disp_tag 9", DW'(dispTag), 9);
        tick();
        @(negedge clk);
        checkOutput("seq empty count", DW'(freeCount), 0);
        tick();

        // All four FUs request continuously from reset.
        rst = 1'b1;
        applyStimulus(1'b0, 4'b0000);
        tick();
        rst = 1'b0;
        for (int i = 0; i < NF; i++) setFu(i, TW'(8'h20 + i), DW'(12'h100 + i));
        applyStimulus(1'b0, 4'b1111);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checkOutput("cont grant", DW'(fuGrant), DW'(grantSeq[k]));
            if (k > 0) checkOutput("cont bcast_tag", DW'(bcastTag), DW'(8'h20 + ((k - 1) % 4)));
            tick();
        end
        @(negedge clk);
        checkOutput("cont last bcast_tag", DW'(bcastTag), 8'h20);
        tick();

        // Full pool, FU0 returns tag 2: dropped and flagged.
        rst = 1'b1;
        applyStimulus(1'b0, 4'b0000);
        tick();
        rst = 1'b0;
        applyStimulus(1'b0, 4'b0001);
        setFu(0, 8'd2, 128'h22);
        @(negedge clk);
        checkOutput("ovf err before", DW'(errOverflow), 0);
        tick();
        applyStimulus(1'b0, 4'b0000);
        @(negedge clk);
        checkOutput("ovf bcast_tag", DW'(bcastTag), 2);
        tick();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput("ovf err sticky", DW'(errOverflow), 1);
            checkOutput("ovf free_count", DW'(freeCount), 16);
            tick();
        end

        // Take 9 tags, start a broadcast, then reset with it in flight.
        applyStimulus(1'b1, 4'b0000);
        repeat (9) tick();
        applyStimulus(1'b0, 4'b0001);
        setFu(0, 8'd3, 128'h33);
        @(negedge clk);
        checkOutput("mid count", DW'(freeCount), 7);
        tick();
        applyStimulus(1'b0, 4'b0000);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("mid bcast", DW'(bcast), 1);
        checkOutput("mid err", DW'(errOverflow), 1);
        tick();
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post rst bcast", DW'(bcast), 0);
        checkOutput("post rst free_count", DW'(freeCount), 16);
        checkOutput("post rst disp_tag", DW'(dispTag), 0);
        checkOutput("post rst err", DW'(errOverflow), 0);
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
